// File: rtl/dmem_bridge.sv
// Bridges the CPU MEM stage to a single-master Wishbone-style bus.
// Handles byte/half/word lanes, sign/zero extension, misalignment traps and bus timeouts.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  mem_type,
  input  logic        mem_ext,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_unalign,
  output logic        bus_error,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dout,
  input  logic [31:0] wb_din,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        req;
  logic        misaligned;
  logic        start;
  logic        finish_ack;
  logic        finish_tmo;
  logic [3:0]  sel_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  tmo_cnt;
  logic [1:0]  lat_type;
  logic        lat_ext;
  logic [1:0]  lat_lane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;
  logic [31:0] result;

  assign req     = mem_ren | mem_wen;
  assign mem_din = (state == DONE) ? result : 32'h0;

  always_comb begin
    misaligned = 1'b0;
    sel_calc   = 4'b1111;
    wdata_calc = mem_dout;
    case (mem_type)
      2'd0: begin
        sel_calc   = 4'b0001 << mem_addr[1:0];
        wdata_calc = {4{mem_dout[7:0]}};
      end
      2'd1: begin
        misaligned = mem_addr[0];
        sel_calc   = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{mem_dout[15:0]}};
      end
      default: misaligned = (mem_addr[1:0] != 2'b00);
    endcase
  end

  // Lane extraction uses the latched address/type so the CPU may change inputs during BUSY
  always_comb begin
    rd_byte = wb_din[7:0];
    case (lat_lane)
      2'd1:    rd_byte = wb_din[15:8];
      2'd2:    rd_byte = wb_din[23:16];
      2'd3:    rd_byte = wb_din[31:24];
      default: rd_byte = wb_din[7:0];
    endcase
    rd_half = lat_lane[1] ? wb_din[31:16] : wb_din[15:0];
    case (lat_type)
      2'd0:    rd_fmt = {{24{lat_ext & rd_byte[7]}}, rd_byte};
      2'd1:    rd_fmt = {{16{lat_ext & rd_half[15]}}, rd_half};
      default: rd_fmt = wb_din;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_stall   = 1'b0;
    mem_unalign = 1'b0;
    start       = 1'b0;
    finish_ack  = 1'b0;
    finish_tmo  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            mem_unalign = 1'b1;
          end else begin
            mem_stall  = 1'b1;
            start      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (wb_ack) begin
          finish_ack = 1'b1;
          state_next = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          finish_tmo = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= 32'h0;
      wb_sel    <= 4'h0;
      wb_dout   <= 32'h0;
      tmo_cnt   <= 8'h0;
      lat_type  <= 2'd0;
      lat_ext   <= 1'b0;
      lat_lane  <= 2'd0;
      result    <= 32'h0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= finish_tmo;
      if (start) begin
        wb_cyc   <= 1'b1;
        wb_stb   <= 1'b1;
        wb_we    <= mem_wen;
        wb_addr  <= {mem_addr[31:2], 2'b00};
        wb_sel   <= sel_calc;
        wb_dout  <= wdata_calc;
        lat_type <= mem_type;
        lat_ext  <= mem_ext;
        lat_lane <= mem_addr[1:0];
        tmo_cnt  <= 8'h0;
      end else if (finish_ack || finish_tmo) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
        result <= (finish_ack && !wb_we) ? rd_fmt : 32'h0;
      end else if (state == BUSY) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge; each task drives one scenario and checks against hand-computed values.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren = 1'b0, mem_wen = 1'b0, mem_ext = 1'b0;
  logic [1:0]  mem_type = 2'd0;
  logic [31:0] mem_addr = 32'h0, mem_dout = 32'h0;
  logic [31:0] mem_din;
  logic        mem_stall, mem_unalign, bus_error;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_dout;
  logic [3:0]  wb_sel;
  logic [31:0] wb_din = 32'h0;
  logic        wb_ack = 1'b0;
  int errors = 0;
  int checks = 0;

  dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_type(mem_type), .mem_ext(mem_ext),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_stall(mem_stall), .mem_unalign(mem_unalign), .bus_error(bus_error),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .wb_dout(wb_dout), .wb_din(wb_din), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic ren, input logic wen, input logic [1:0] typ,
                         input logic ext, input logic [31:0] addr, input logic [31:0] dout);
    mem_ren = ren; mem_wen = wen; mem_type = typ; mem_ext = ext;
    mem_addr = addr; mem_dout = dout;
  endtask

  task automatic clear_req();
    mem_ren = 1'b0; mem_wen = 1'b0; mem_type = 2'd0; mem_ext = 1'b0;
    mem_addr = 32'h0; mem_dout = 32'h0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL reset_ctl: got cyc=%b stb=%b we=%b expected 0", wb_cyc, wb_stb, wb_we); end
    checks++; if (wb_addr !== 32'h0 || wb_sel !== 4'h0 || wb_dout !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h sel=%b dout=%h expected 0", wb_addr, wb_sel, wb_dout); end
    checks++; if (mem_din !== 32'h0 || mem_stall !== 1'b0 || mem_unalign !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL reset_cpu: got din=%h stall=%b unalign=%b berr=%b expected 0", mem_din, mem_stall, mem_unalign, bus_error); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_word_read();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    #1;
    checks++; if (mem_stall !== 1'b1 || wb_cyc !== 1'b0) begin errors++; $display("FAIL wr_req_cycle: got stall=%b cyc=%b expected 1/0", mem_stall, wb_cyc); end
    step();
    checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b0 || mem_stall !== 1'b1) begin errors++; $display("FAIL wr_busy_ctl: got cyc=%b stb=%b we=%b stall=%b expected 1/1/0/1", wb_cyc, wb_stb, wb_we, mem_stall); end
    checks++; if (wb_addr !== 32'h100 || wb_sel !== 4'b1111) begin errors++; $display("FAIL wr_busy_bus: got addr=%h sel=%b expected 00000100/1111", wb_addr, wb_sel); end
    wb_din = 32'h8899AABB; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; wb_din = 32'h0;
    checks++; if (mem_din !== 32'h8899AABB || mem_stall !== 1'b0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL wr_done: got din=%h stall=%b cyc=%b expected 8899aabb/0/0", mem_din, mem_stall, wb_cyc); end
    clear_req();
    step();
    checks++; if (mem_din !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL wr_idle_after: got din=%h stall=%b expected 0/0", mem_din, mem_stall); end
  endtask

  task automatic test_subword_read();
    logic [1:0]  typ [3] = '{2'd0, 2'd0, 2'd1};
    logic        ext [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
    logic [3:0]  sel [3] = '{4'b1000, 4'b1000, 4'b1100};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012};
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, typ[i], ext[i], adr[i], 32'h0);
      step();
      checks++; if (wb_sel !== sel[i] || wb_addr !== 32'h100) begin errors++; $display("FAIL sub_bus[%0d]: got sel=%b addr=%h expected %b/00000100", i, wb_sel, wb_addr, sel[i]); end
      wb_din = 32'h80123456; wb_ack = 1'b1;
      step();
      wb_ack = 1'b0; wb_din = 32'h0;
      checks++; if (mem_din !== exp[i]) begin errors++; $display("FAIL sub_data[%0d]: got %h expected %h", i, mem_din, exp[i]); end
      clear_req();
      step();
    end
  endtask

  task automatic test_write();
    set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF);
    step();
    checks++; if (wb_we !== 1'b1 || wb_addr !== 32'h200 || wb_sel !== 4'b1100 || wb_dout !== 32'hBEEFBEEF) begin errors++; $display("FAIL hw_bus: got we=%b addr=%h sel=%b dout=%h expected 1/00000200/1100/beefbeef", wb_we, wb_addr, wb_sel, wb_dout); end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    checks++; if (mem_din !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL hw_done: got din=%h stall=%b expected 0/0", mem_din, mem_stall); end
    clear_req();
    step();
    // both enables high: write wins, returned data must stay zero
    set_req(1'b1, 1'b1, 2'd0, 1'b1, 32'h301, 32'h123456A5);
    step();
    checks++; if (wb_we !== 1'b1 || wb_sel !== 4'b0010 || wb_dout !== 32'hA5A5A5A5) begin errors++; $display("FAIL bw_bus: got we=%b sel=%b dout=%h expected 1/0010/a5a5a5a5", wb_we, wb_sel, wb_dout); end
    wb_din = 32'hFFFFFFFF; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; wb_din = 32'h0;
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL bw_done: got din=%h expected 0", mem_din); end
    clear_req();
    step();
  endtask

  task automatic test_unalign();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    #1;
    checks++; if (mem_unalign !== 1'b1 || mem_stall !== 1'b0 || mem_din !== 32'h0) begin errors++; $display("FAIL ua_word: got unalign=%b stall=%b din=%h expected 1/0/0", mem_unalign, mem_stall, mem_din); end
    clear_req();
    step();
    checks++; if (wb_cyc !== 1'b0 || mem_unalign !== 1'b0) begin errors++; $display("FAIL ua_word_after: got cyc=%b unalign=%b expected 0/0", wb_cyc, mem_unalign); end
    set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h203, 32'h1234);
    #1;
    checks++; if (mem_unalign !== 1'b1 || mem_stall !== 1'b0) begin errors++; $display("FAIL ua_half: got unalign=%b stall=%b expected 1/0", mem_unalign, mem_stall); end
    clear_req();
    step();
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL ua_half_after: got cyc=%b expected 0", wb_cyc); end
  endtask

  task automatic test_timeout();
    int busy;
    busy = 0;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    wb_din = 32'hDEADBEEF;
    step();
    checks++; if (mem_stall !== 1'b1 || bus_error !== 1'b0) begin errors++; $display("FAIL to_busy: got stall=%b berr=%b expected 1/0", mem_stall, bus_error); end
    for (int i = 0; i < 20; i++) begin
      if (wb_cyc !== 1'b1) break;
      busy++;
      step();
    end
    checks++; if (busy != 4) begin errors++; $display("FAIL to_cycles: got %0d busy cycles expected 4", busy); end
    checks++; if (bus_error !== 1'b1 || wb_cyc !== 1'b0 || mem_din !== 32'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL to_done: got berr=%b cyc=%b din=%h stall=%b expected 1/0/0/0", bus_error, wb_cyc, mem_din, mem_stall); end
    clear_req();
    wb_din = 32'h0;
    step();
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_pulse: got berr=%b expected 0", bus_error); end
  endtask

  task automatic test_reset_abort();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
    step();
    clear_req();
    checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL ra_busy: got cyc=%b expected 1", wb_cyc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_addr !== 32'h0 || wb_sel !== 4'h0 || mem_stall !== 1'b0) begin errors++; $display("FAIL ra_async: got cyc=%b stb=%b addr=%h sel=%b stall=%b expected 0", wb_cyc, wb_stb, wb_addr, wb_sel, mem_stall); end
    step();
    rst = 1'b0;
    wb_din = 32'h11223344; wb_ack = 1'b1;
    step();
    step();
    checks++; if (wb_cyc !== 1'b0 || mem_din !== 32'h0 || mem_stall !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL ra_late_ack: got cyc=%b din=%h stall=%b berr=%b expected 0", wb_cyc, mem_din, mem_stall, bus_error); end
    wb_ack = 1'b0; wb_din = 32'h0;
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
    step();
    wb_din = 32'hCAFEF00D; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; wb_din = 32'h0;
    set_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h601, 32'h0);
    #1;
    checks++; if (mem_din !== 32'hCAFEF00D || mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_done: got din=%h stall=%b expected cafef00d/0", mem_din, mem_stall); end
    step();
    checks++; if (wb_cyc !== 1'b0 || mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_idle: got cyc=%b stall=%b expected 0/1", wb_cyc, mem_stall); end
    step();
    checks++; if (wb_cyc !== 1'b1 || wb_addr !== 32'h600 || wb_sel !== 4'b0010) begin errors++; $display("FAIL b2b_busy: got cyc=%b addr=%h sel=%b expected 1/00000600/0010", wb_cyc, wb_addr, wb_sel); end
    wb_din = 32'h0000AB00; wb_ack = 1'b1;
    step();
    wb_ack = 1'b0; wb_din = 32'h0;
    checks++; if (mem_din !== 32'h000000AB) begin errors++; $display("FAIL b2b_data: got %h expected 000000ab", mem_din); end
    clear_req();
    step();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_subword_read();
    test_write();
    test_unalign();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, BUSY cycles allowed without wb_ack before abort (1..255).
REQ-002 clk  input  1  single clock for all state, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_ren  input  1  CPU MEM-stage read request.
REQ-005 mem_wen  input  1  CPU MEM-stage write request.
REQ-006 mem_type  input  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
REQ-007 mem_ext  input  1  1 = sign-extend read data, 0 = zero-extend.
REQ-008 mem_addr  input  32  byte address.
REQ-009 mem_dout  input  32  CPU write data, right-aligned.
REQ-010 mem_din  output  32  formatted read data to CPU.
REQ-011 mem_stall  output  1  CPU MEM stage must hold while high.
REQ-012 mem_unalign  output  1  one-cycle misaligned-access exception pulse.
REQ-013 bus_error  output  1  one-cycle bus-timeout pulse.
REQ-014 wb_cyc, wb_stb  output  1 each  bus cycle/strobe, registered.
REQ-015 wb_we  output  1  bus write, registered.
REQ-016 wb_addr  output  32  word address, bits [1:0] = 0, registered.
REQ-017 wb_sel  output  4  byte lane enables, registered.
REQ-018 wb_dout  output  32  bus write data, registered.
REQ-019 wb_din  input  32  bus read data, valid with wb_ack.
REQ-020 wb_ack  input  1  bus completion.

Function
REQ-021 FSM states IDLE, BUSY, DONE; request = mem_ren | mem_wen.
REQ-022 Little-endian lanes: addr[1:0]=n selects bits [8n+7:8n]; byte sel = 1<<addr[1:0]; half sel = 0011 (addr[1]=0) or 1100; word sel = 1111.
REQ-023 Misaligned: half with addr[0]=1, word/type3 with addr[1:0]!=0.
REQ-024 IDLE, aligned request: mem_stall=1 combinationally same cycle; latch addr/type/ext/we/sel/data; next cycle wb_cyc=wb_stb=1, state BUSY.
REQ-025 IDLE, misaligned request: no bus cycle, mem_unalign=1 combinationally that cycle, mem_stall=0, mem_din=0, stay IDLE.
REQ-026 mem_ren and mem_wen both high: write performed, mem_din=0 in DONE.
REQ-027 Write data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-028 BUSY: mem_stall=1; wb_cyc/wb_stb held with stable addr/sel/we/dout until wb_ack or timeout.
REQ-029 BUSY with wb_ack=1: register selected lane(s) of wb_din, extended per latched type/ext (word unchanged); next cycle wb_cyc=wb_stb=0, state DONE.
REQ-030 Timeout counter cleared on BUSY entry, increments each BUSY cycle without ack; on reaching TIMEOUT_CYCLES: drop wb_cyc/wb_stb next cycle, bus_error=1 for one cycle, read data forced 0, state DONE.
REQ-031 DONE: mem_stall=0, mem_din = registered result, no new request accepted; next cycle unconditionally IDLE.
REQ-032 Minimum latency: request cycle N, ack in N+1, DONE in N+2; mem_stall high exactly cycles N and N+1.
REQ-033 Back-to-back: new request presented in cycle after DONE starts in IDLE normally.
REQ-034 wb_ack outside BUSY ignored; mem_din outside DONE = 0.

Reset
REQ-035 rst asynchronously forces IDLE, wb_cyc=wb_stb=wb_we=0, wb_addr=0, wb_sel=0, wb_dout=0, timeout counter 0, result register 0, mem_unalign=bus_error=0.
REQ-036 rst during BUSY aborts immediately; later wb_ack for aborted cycle ignored.
REQ-037 After rst release, mem_stall follows REQ-024 from the first clock.

Verification
REQ-038 Word read addr 0x100, wb_din=0x8899AABB, ack 1st BUSY cycle -> wb_sel=1111, wb_addr=0x100, stall 2 cycles, mem_din=0x8899AABB in DONE.
REQ-039 Byte read addr 0x103, ext=1, wb_din=0x80123456 -> wb_sel=1000, mem_din=0xFFFFFF80; ext=0 -> 0x00000080.
REQ-040 Half write addr 0x202, mem_dout=0x0000BEEF -> wb_we=1, wb_addr=0x200, wb_sel=1100, wb_dout=0xBEEFBEEF.
REQ-041 Word read addr 0x101 -> no wb_cyc, mem_unalign=1 one cycle, mem_stall=0.
REQ-042 TIMEOUT_CYCLES=4, wb_ack never -> 4 BUSY cycles, bus_error pulse, wb_cyc drops, DONE mem_din=0.
REQ-043 rst asserted mid-BUSY, then late wb_ack -> outputs zero immediately, state IDLE, ack ignored.
